bcd_time_ascii_tx: RTL and testbench

BCD_TIME_ASCII_TX -- requirements
Module: bcd_time_ascii_tx

---
 rtl/bcd_time_ascii_tx.sv | 128 ++++++++++++
 tb/tb_bcd_time_ascii_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_ascii_tx.sv
// Serialises six latched BCD time digits into an ASCII frame
// "HH.MM.SS|" (plus optional LF) over a valid/ready byte stream.
module bcd_time_ascii_tx #(
  parameter bit         TERM_EN = 1'b1,
  parameter logic [7:0] SEP     = 8'h2E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] ms_hr,
  input  logic [3:0] ls_hr,
  input  logic [3:0] ms_min,
  input  logic [3:0] ls_min,
  input  logic [3:0] ms_sec,
  input  logic [3:0] ls_sec,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       bad_digit
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [3:0] LAST_IDX = TERM_EN ? 4'd9 : 4'd8;

  localparam logic [7:0] BAR = 8'h7C;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] QM  = 8'h3F;

  logic [0:0]      state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic            done_q, done_d;
  logic            bad_q, bad_d;

  logic [5:0][3:0] dig_in;
  logic            in_bad;
  logic            fire;
  logic [7:0]      byte_sel;

  // Index 0 is the first digit on the wire (ms_hr).
  assign dig_in = {ls_sec, ms_sec, ls_min, ms_min, ls_hr, ms_hr};

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : QM;
  endfunction

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (dig_in[i] > 4'd9) in_bad = 1'b1;
    end
  end

  assign tx_valid = (state_q == S_SEND);
  assign busy     = tx_valid;
  assign done     = done_q;
  assign bad_digit = bad_q;
  assign fire     = tx_valid & tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    bad_d   = bad_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dig_d   = dig_in;
          bad_d   = in_bad;
          idx_d   = 4'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    unique case (idx_q)
      4'd0:    byte_sel = to_ascii(dig_q[0]);
      4'd1:    byte_sel = to_ascii(dig_q[1]);
      4'd2:    byte_sel = SEP;
      4'd3:    byte_sel = to_ascii(dig_q[2]);
      4'd4:    byte_sel = to_ascii(dig_q[3]);
      4'd5:    byte_sel = SEP;
      4'd6:    byte_sel = to_ascii(dig_q[4]);
      4'd7:    byte_sel = to_ascii(dig_q[5]);
      4'd8:    byte_sel = BAR;
      default: byte_sel = LF;
    endcase
  end

  assign tx_data = tx_valid ? byte_sel : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      dig_q   <= '0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
    end
  end

endmodule

// File: tb/tb_bcd_time_ascii_tx.sv
// Scoreboard bench: unit 0 has the LF terminator, unit 1 does not.
// Stimulus pushes expected frames; a negedge monitor checks every cycle.
module tb_bcd_time_ascii_tx;

  typedef logic [5:0][3:0] dig_t;
  typedef struct { logic [7:0] d; bit last; } ent_t;
  typedef struct { string nm; int u; logic [31:0] got; logic [31:0] exp; } chk_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s [2];
  logic [3:0] dg [2][6];
  logic       rdy [2];
  logic [7:0] txd [2];
  logic       txv [2];
  logic       bsy [2];
  logic       dn [2];
  logic       bad [2];

  ent_t q [2][$];
  chk_t cq [$];
  bit   exp_bad [2];
  bit   pend [2];
  int   rmode [2];
  bit   mon_en = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  bcd_time_ascii_tx #(.TERM_EN(1'b1), .SEP(8'h2E)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .ms_hr(dg[0][0]), .ls_hr(dg[0][1]),
    .ms_min(dg[0][2]), .ls_min(dg[0][3]),
    .ms_sec(dg[0][4]), .ls_sec(dg[0][5]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(rdy[0]),
    .busy(bsy[0]), .done(dn[0]), .bad_digit(bad[0])
  );

  bcd_time_ascii_tx #(.TERM_EN(1'b0), .SEP(8'h2E)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .ms_hr(dg[1][0]), .ls_hr(dg[1][1]),
    .ms_min(dg[1][2]), .ls_min(dg[1][3]),
    .ms_sec(dg[1][4]), .ls_sec(dg[1][5]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(rdy[1]),
    .busy(bsy[1]), .done(dn[1]), .bad_digit(bad[1])
  );

  function automatic logic [7:0] asc(input logic [3:0] v);
    return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h3F;
  endfunction

  task automatic set_dig(input int u, input dig_t d);
    for (int i = 0; i < 6; i++) dg[u][i] = d[i];
  endtask

  task automatic push_frame(input int u, input dig_t d);
    logic [7:0] b [$];
    b = '{asc(d[0]), asc(d[1]), 8'h2E, asc(d[2]), asc(d[3]),
          8'h2E, asc(d[4]), asc(d[5]), 8'h7C};
    if (u == 0) b.push_back(8'h0A);
    for (int i = 0; i < b.size(); i++)
      q[u].push_back('{b[i], i == b.size() - 1});
    exp_bad[u] = 1'b0;
    for (int i = 0; i < 6; i++) if (d[i] > 4'd9) exp_bad[u] = 1'b1;
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    while (q[u].size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) cq.push_back('{"frame_timeout", u, 32'd1, 32'd0});
    @(posedge clk);
  endtask

  task automatic do_frame(input int u, input dig_t d, input int mode,
                          input bit mid, input dig_t dm);
    rmode[u] = mode;
    @(posedge clk); #2;
    set_dig(u, d);
    start_s[u] = 1'b1;
    @(posedge clk); #1;
    push_frame(u, d);
    #1 start_s[u] = 1'b0;
    if (mid) begin
      repeat (2) @(posedge clk);
      #2 set_dig(u, dm);
      start_s[u] = 1'b1;
      @(posedge clk);
      #2 start_s[u] = 1'b0;
    end
    if (mode == 3) begin
      repeat (40) @(posedge clk);
      #2 rmode[u] = 2;
    end
    wait_idle(u);
  endtask

  function automatic dig_t rnd_dig();
    dig_t d;
    for (int i = 0; i < 6; i++)
      d[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                         : 4'($urandom_range(0, 9));
    return d;
  endfunction

  task automatic chk(input string nm, input int u,
                     input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s unit%0d t=%0t got=%0h exp=%0h", nm, u, $time, got, exp);
    end
  endtask

  // ready generator: 0 high, 1 toggle, 2 random, 3 held low
  initial begin
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        case (rmode[u])
          0: rdy[u] = 1'b1;
          1: rdy[u] = ~rdy[u];
          2: rdy[u] = 1'($urandom_range(0, 1));
          default: rdy[u] = 1'b0;
        endcase
      end
    end
  end

  initial begin
    chk_t c;
    ent_t e;
    bit   qs;
    forever begin
      @(negedge clk);
      while (cq.size() > 0) begin
        c = cq.pop_front();
        chk(c.nm, c.u, c.got, c.exp);
      end
      if (mon_en) begin
        for (int u = 0; u < 2; u++) begin
          qs = q[u].size() > 0;
          chk("tx_valid", u, {31'd0, txv[u]}, {31'd0, qs});
          chk("busy", u, {31'd0, bsy[u]}, {31'd0, qs});
          chk("done", u, {31'd0, dn[u]}, {31'd0, pend[u]});
          chk("bad_digit", u, {31'd0, bad[u]}, {31'd0, exp_bad[u]});
          if (qs) chk("tx_data", u, {24'd0, txd[u]}, {24'd0, q[u][0].d});
          else    chk("idle_data", u, {24'd0, txd[u]}, 32'd0);
          pend[u] = 1'b0;
          if (qs && txv[u] === 1'b1 && rdy[u]) begin
            e = q[u].pop_front();
            pend[u] = e.last;
          end
        end
      end
    end
  end

  initial begin
    dig_t z = '0;
    dig_t d;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      rmode[u] = 0;
      exp_bad[u] = 1'b0;
      pend[u] = 1'b0;
      set_dig(u, z);
    end
    reset = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    d = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    do_frame(0, d, 0, 1'b0, z);
    do_frame(0, d, 1, 1'b0, z);
    d = {4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2};
    do_frame(0, d, 0, 1'b1, z);

    d = {4'd6, 4'd5, 4'hC, 4'd3, 4'd2, 4'd1};
    do_frame(1, d, 0, 1'b0, z);
    d = {4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd1};
    do_frame(1, d, 1, 1'b1, rnd_dig());

    for (int k = 0; k < 40; k++) begin
      do_frame(k % 2, rnd_dig(), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), rnd_dig());
    end

    // start held high: frames every L+1 cycles, one idle (done) cycle between
    rmode[0] = 0;
    d = {4'd7, 4'd5, 4'd1, 4'd4, 4'd2, 4'd2};
    @(posedge clk); #2;
    set_dig(0, d);
    start_s[0] = 1'b1;
    @(posedge clk); #1 push_frame(0, d);
    for (int f = 1; f < 3; f++) begin
      repeat (10) @(posedge clk);
      @(posedge clk); #1 push_frame(0, d);
    end
    repeat (10) @(posedge clk);
    #2 start_s[0] = 1'b0;
    wait_idle(0);

    // reset after the 4th byte transfers abandons the frame
    d = {4'd8, 4'd1, 4'd3, 4'd0, 4'd9, 4'd1};
    @(posedge clk); #2;
    set_dig(0, d);
    start_s[0] = 1'b1;
    @(posedge clk); #1 push_frame(0, d);
    #1 start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    q[0].delete();
    q[1].delete();
    exp_bad[0] = 1'b0;
    exp_bad[1] = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    do_frame(0, d, 2, 1'b0, z);
    do_frame(1, rnd_dig(), 0, 1'b0, z);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog");
  end

endmodule
